// File: rtl/addsub_seq.sv
// addsub_seq: nibble-serial two's complement add/subtract, one 4-bit nibble per cycle.
// Define ADDSUB_SAT_EN to saturate the result on signed overflow.
module addsub_seq #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]   state;
  logic [3:0]   cnt;
  logic [W-1:0] ra, rb, nr, fin;
  logic         carry, v, last;
  logic [4:0]   s;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign last = cnt == 4'(NIBBLES - 1);
  // rb already holds ~b for subtract, so one overflow rule covers both ops
  always_comb begin
    s = {1'b0, ra[4*cnt +: 4]} + {1'b0, rb[4*cnt +: 4]} + {4'b0, carry};
    nr = result;
    nr[4*cnt +: 4] = s[3:0];
    v = (ra[W-1] == rb[W-1]) && (nr[W-1] != ra[W-1]);
`ifdef ADDSUB_SAT_EN
    fin = v ? (ra[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : nr;
`else
    fin = nr;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      ra     <= '0;
      rb     <= '0;
      carry  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        state <= RUN;
        ra    <= a;
        rb    <= op ? ~b : b;
        carry <= op;
        cnt   <= '0;
      end
    end else if (state == RUN) begin
      carry <= s[4];
      if (last) begin
        state  <= DONE;
        result <= fin;
        cout   <= s[4];
        ovf    <= v;
        cnt    <= '0;
      end else begin
        result <= nr;
        cnt    <= cnt + 4'd1;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_addsub_seq.sv
// tb_addsub_seq: directed checks of addsub_seq timing, arithmetic, overflow and reset.
module tb_addsub_seq;
  logic        clk, rst_n, start, op, busy, done, cout, ovf;
  logic [15:0] a, b, result;
  int          total, bad;
  logic [15:0] exp_r;
  addsub_seq #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  // issues one operation and scrambles the operand inputs right after acceptance
  task automatic run_op(input string tag, input logic o, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] er, input logic ec, input logic ev);
    @(negedge clk);
    start = 1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 0; op = ~o; a = ~x; b = y ^ 16'h5a5a;
    chk({tag, " busy0"}, busy, 1);
    chk({tag, " done0"}, done, 0);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      chk({tag, " busyn"}, busy, 1);
      chk({tag, " donen"}, done, 0);
    end
    @(posedge clk); #1;
    chk({tag, " busy4"}, busy, 0);
    chk({tag, " done4"}, done, 1);
    chk({tag, " result"}, result, er);
    chk({tag, " cout"}, cout, ec);
    chk({tag, " ovf"}, ovf, ev);
    @(posedge clk); #1;
    chk({tag, " done5"}, done, 0);
    chk({tag, " hold"}, result, er);
  endtask
  initial begin
    total = 0; bad = 0;
    clk = 0; rst_n = 0; start = 0; op = 0; a = 0; b = 0;
    #7;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst result", result, 0);
    chk("rst cout", cout, 0);
    chk("rst ovf", ovf, 0);
    @(negedge clk); rst_n = 1;
    run_op("add1", 0, 16'h1234, 16'h0FFF, 16'h2233, 0, 0);
    run_op("sub1", 1, 16'h0000, 16'h0001, 16'hFFFF, 0, 0);
`ifdef ADDSUB_SAT_EN
    run_op("addovf", 0, 16'h7FFF, 16'h0001, 16'h7FFF, 0, 1);
    run_op("subovf", 1, 16'h8000, 16'h0001, 16'h8000, 1, 1);
    run_op("negovf", 0, 16'h8000, 16'h8000, 16'h8000, 1, 1);
`else
    run_op("addovf", 0, 16'h7FFF, 16'h0001, 16'h8000, 0, 1);
    run_op("subovf", 1, 16'h8000, 16'h0001, 16'h7FFF, 1, 1);
    run_op("negovf", 0, 16'h8000, 16'h8000, 16'h0000, 1, 1);
`endif
    run_op("wrap", 0, 16'hFFFF, 16'h0001, 16'h0000, 1, 0);
    run_op("sub2", 1, 16'h0005, 16'h0003, 16'h0002, 1, 0);
    // start held high while operands change every cycle: acceptances at edges 0, 6, 12
    exp_r = 0;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      start = 1;
      a = 16'h1000 + 16'(i) * 16'h0111;
      b = 16'(i) * 16'h0202;
      op = (i % 4) >= 2;
      if (i % 6 == 0) exp_r = op ? a - b : a + b;
      @(posedge clk); #1;
      if (i >= 4 && (i - 4) % 6 == 0) begin
        chk("held done", done, 1);
        chk("held result", result, exp_r);
      end else begin
        chk("held nodone", done, 0);
      end
    end
    @(negedge clk); start = 0;
    repeat (2) @(negedge clk);
    // reset in the second nibble cycle aborts the operation
    start = 1; op = 0; a = 16'h1234; b = 16'h0FFF;
    @(posedge clk); #1; start = 0;
    @(posedge clk); #2;
    rst_n = 0; #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort result", result, 0);
    chk("abort cout", cout, 0);
    chk("abort ovf", ovf, 0);
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort nodone", done, 0);
    end
    run_op("post", 0, 16'h1234, 16'h0FFF, 16'h2233, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
